// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and frame constants for the instruction memory loader
//
// Purpose : loader FSM state encoding and byte-stream framing constants,
//           imported by imem_loader and imem_word_packer.
// Ports   : none (package).

package imem_loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LEN   = 3'd1,
      S_DATA  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   // Stream bytes per instruction word
   localparam int BYTES_PER_WORD = 4;

   // A length byte of zero requests a full-depth load
   localparam bit LEN_ZERO_MEANS_FULL = 1'b1;

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - byte-to-word shift register for the instruction memory loader
//
// Purpose : assembles big-endian stream bytes into DATA_WIDTH-bit words.
// Ports   : i_clk, i_reset   clock and synchronous active-high reset
//           i_clear          restarts byte counting at a word boundary
//           i_byte_valid     a byte is accepted this cycle
//           i_byte           accepted byte
//           o_word           word including the byte on i_byte (valid with o_word_valid)
//           o_word_valid     pulse in the cycle the last byte of a word is accepted

module imem_word_packer
   import imem_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clear,
   input  logic                  i_byte_valid,
   input  logic [7:0]            i_byte,
   output logic [DATA_WIDTH-1:0] o_word,
   output logic                  o_word_valid
);

   // Only the first three bytes of a word need storage; the fourth is
   // taken straight from i_byte so the word is available in the same cycle.
   logic [DATA_WIDTH-9:0] r_shift;
   logic [1:0]            r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_shift <= '0;
         r_cnt   <= 2'd0;
      end else if (i_byte_valid) begin
         r_shift <= {r_shift[DATA_WIDTH-17:0], i_byte};
         r_cnt   <= r_cnt + 2'd1;
      end
   end

   assign o_word       = {r_shift, i_byte};
   assign o_word_valid = i_byte_valid && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream program loader for the instruction memory
//
// Purpose : receives [L][4*N instruction bytes, MSB first][XOR checksum],
//           writes each word to the instruction memory and releases the
//           processor reset once a frame completes with a good checksum.
// Ports   : i_clk, i_reset   clock and synchronous active-high reset
//           i_start          one-cycle pulse starting a new frame (IDLE/DONE/ERR only)
//           i_in_valid       byte source has a byte on i_in_byte
//           i_in_byte        stream byte
//           o_in_ready       byte accepted when i_in_valid && o_in_ready
//           o_wr_en          one-cycle instruction memory write strobe
//           o_wr_addr        byte address of the word (index << 2)
//           o_wr_data        instruction word
//           o_busy           frame in progress
//           o_done           last frame loaded with good checksum (sticky)
//           o_error          last frame failed on length or checksum (sticky)
//           o_cpu_reset      processor reset, low only while o_done is high

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int SIZE       = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic                  i_in_valid,
   input  logic [7:0]            i_in_byte,
   output logic                  o_in_ready,
   output logic                  o_wr_en,
   output logic [31:0]           o_wr_addr,
   output logic [DATA_WIDTH-1:0] o_wr_data,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_error,
   output logic                  o_cpu_reset
);

   // One extra bit so that N = SIZE is representable
   localparam int         IDX_W  = $clog2(SIZE) + 1;
   localparam logic [8:0] SIZE_L = 9'(SIZE);

   state_t                r_state;
   logic [IDX_W-1:0]      r_index;
   logic [IDX_W-1:0]      r_n;
   logic [7:0]            r_csum;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic                  r_wr_en;
   logic [31:0]           r_wr_addr;
   logic [DATA_WIDTH-1:0] r_wr_data;

   logic                  w_accept;
   logic                  w_data_byte;
   logic                  w_start_ok;
   logic                  w_len_bad;
   logic [IDX_W-1:0]      w_len_n;
   logic [IDX_W-1:0]      w_index_next;
   logic [31:0]           w_wr_addr;
   logic [DATA_WIDTH-1:0] w_word;
   logic                  w_word_valid;

   // in_ready and busy coincide: both are high exactly in LEN, DATA, CHECK
   assign w_accept     = i_in_valid && r_busy;
   assign w_data_byte  = w_accept && (r_state == S_DATA);
   assign w_start_ok   = i_start && ((r_state == S_IDLE) ||
                                     (r_state == S_DONE) ||
                                     (r_state == S_ERR));
   assign w_len_bad    = {1'b0, i_in_byte} > SIZE_L;
   assign w_len_n      = (LEN_ZERO_MEANS_FULL && (i_in_byte == 8'd0)) ?
                         IDX_W'(SIZE) : IDX_W'(i_in_byte);
   assign w_index_next = r_index + 1'b1;
   assign w_wr_addr    = 32'({r_index, 2'b00});

   imem_word_packer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (w_start_ok),
      .i_byte_valid (w_data_byte),
      .i_byte       (i_in_byte),
      .o_word       (w_word),
      .o_word_valid (w_word_valid)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_index   <= '0;
         r_n       <= '0;
         r_csum    <= 8'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_error   <= 1'b0;
         r_wr_en   <= 1'b0;
         r_wr_addr <= 32'd0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (w_start_ok) begin
                  r_index <= '0;
                  r_csum  <= 8'd0;
                  r_done  <= 1'b0;
                  r_error <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_LEN;
               end
            end

            S_LEN: begin
               if (w_accept) begin
                  if (w_len_bad) begin
                     r_error <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_ERR;
                  end else begin
                     r_n     <= w_len_n;
                     // An empty frame can only arise if zero does not mean full
                     r_state <= (w_len_n == '0) ? S_CHECK : S_DATA;
                  end
               end
            end

            S_DATA: begin
               if (w_accept) begin
                  r_csum <= r_csum ^ i_in_byte;
                  if (w_word_valid) begin
                     r_wr_en   <= 1'b1;
                     r_wr_addr <= w_wr_addr;
                     r_wr_data <= w_word;
                     r_index   <= w_index_next;
                     if (w_index_next == r_n) begin
                        r_state <= S_CHECK;
                     end
                  end
               end
            end

            S_CHECK: begin
               if (w_accept) begin
                  r_busy <= 1'b0;
                  if (i_in_byte == r_csum) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_error <= 1'b1;
                     r_state <= S_ERR;
                  end
               end
            end

            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = r_busy;
   assign o_busy      = r_busy;
   assign o_wr_en     = r_wr_en;
   assign o_wr_addr   = r_wr_addr;
   assign o_wr_data   = r_wr_data;
   assign o_done      = r_done;
   assign o_error     = r_error;
   assign o_cpu_reset = ~r_done;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader

module tb_imem_loader;

   localparam int SIZE = 32;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_byte;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        error;
   logic        cpu_reset;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] frame_words [0:255];
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];

   always #5 clk = ~clk;

   imem_loader #(
      .SIZE       (SIZE),
      .DATA_WIDTH (32)
   ) dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_start     (start),
      .i_in_valid  (in_valid),
      .i_in_byte   (in_byte),
      .o_in_ready  (in_ready),
      .o_wr_en     (wr_en),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_busy      (busy),
      .o_done      (done),
      .o_error     (error),
      .o_cpu_reset (cpu_reset)
   );

   // Every write strobe cycle is logged; a stretched strobe shows up as extra entries
   always @(negedge clk) begin
      if (wr_en) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      in_valid = 1'b0;
      start    = 1'b1;
      tick();
      start    = 1'b0;
   endtask

   // Present a byte after 'gap' idle cycles and hold it until accepted
   task automatic send_byte(input logic [7:0] b, input int gap);
      logic acc;
      acc = 1'b0;
      repeat (gap) begin
         in_valid = 1'b0;
         tick();
      end
      in_valid = 1'b1;
      in_byte  = b;
      for (int k = 0; k < 200; k++) begin
         acc = in_ready;
         tick();
         if (acc) break;
      end
      in_valid = 1'b0;
      check_eq("byte_accept", {31'd0, acc}, 32'd1);
   endtask

   task automatic send_frame(input logic [7:0] len, input int n, input logic [7:0] c_flip,
                             input bit gaps, input bit mid_start);
      logic [7:0] cs;
      logic [7:0] b;
      cs = 8'd0;
      log_addr.delete();
      log_data.delete();
      pulse_start();
      check_eq("start_busy", {31'd0, busy}, 32'd1);
      check_eq("start_ready", {31'd0, in_ready}, 32'd1);
      check_eq("start_clr_done", {31'd0, done}, 32'd0);
      check_eq("start_clr_error", {31'd0, error}, 32'd0);
      send_byte(len, 0);
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 4; j++) begin
            b  = frame_words[i][31-8*j -: 8];
            cs = cs ^ b;
            if (mid_start && i == 1 && j == 2) pulse_start();
            send_byte(b, gaps ? int'($urandom_range(0, 2)) : 0);
         end
      end
      send_byte(cs ^ c_flip, 0);
   endtask

   task automatic check_log(input string tag, input int n);
      check_eq({tag, "_count"}, log_addr.size(), n);
      for (int i = 0; i < n && i < log_addr.size(); i++) begin
         check_eq({tag, "_addr"}, log_addr[i], 32'(i * 4));
         check_eq({tag, "_data"}, log_data[i], frame_words[i]);
      end
   endtask

   task automatic check_flags(input string tag, input logic d, input logic e);
      check_eq({tag, "_done"}, {31'd0, done}, {31'd0, d});
      check_eq({tag, "_error"}, {31'd0, error}, {31'd0, e});
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      check_eq({tag, "_cpu_reset"}, {31'd0, cpu_reset}, {31'd0, ~d});
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
      check_eq({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
      check_eq({tag, "_wr_addr"}, wr_addr, 32'd0);
      check_eq({tag, "_wr_data"}, wr_data, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
      check_eq({tag, "_error"}, {31'd0, error}, 32'd0);
      check_eq({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
   endtask

   initial begin
      reset    = 1'b1;
      start    = 1'b0;
      in_valid = 1'b0;
      in_byte  = 8'd0;
      repeat (3) tick();
      check_reset_state("reset");
      reset = 1'b0;
      tick();

      // Basic load: three words, byte XOR of these words is 0x55
      frame_words[0] = 32'h0000_0820;
      frame_words[1] = 32'h0000_1020;
      frame_words[2] = 32'h2009_0064;
      send_frame(8'd3, 3, 8'h00, 1'b0, 1'b0);
      check_flags("basic", 1'b1, 1'b0);
      tick();
      check_log("basic", 3);
      check_eq("basic_hold_addr", wr_addr, 32'd8);
      check_eq("basic_hold_data", wr_data, 32'h2009_0064);

      // Bytes offered while not ready are not consumed and cause no writes
      log_addr.delete();
      in_valid = 1'b1;
      in_byte  = 8'hAA;
      repeat (3) tick();
      in_valid = 1'b0;
      check_eq("idle_no_write", log_addr.size(), 0);
      check_flags("idle_hold", 1'b1, 1'b0);

      // Full-size load: L = 0 means SIZE words
      for (int i = 0; i < SIZE; i++) frame_words[i] = 32'hA500_0000 ^ (32'(i) * 32'h0103_0507);
      send_frame(8'd0, SIZE, 8'h00, 1'b0, 1'b0);
      check_flags("full", 1'b1, 1'b0);
      tick();
      check_log("full", SIZE);
      check_eq("full_last_addr", wr_addr, 32'd124);

      // Bad length
      log_addr.delete();
      log_data.delete();
      pulse_start();
      send_byte(8'd33, 0);
      check_flags("badlen", 1'b0, 1'b1);
      tick();
      check_eq("badlen_no_write", log_addr.size(), 0);

      // Checksum off by one bit, then a good restart
      frame_words[0] = 32'hDEAD_BEEF;
      send_frame(8'd1, 1, 8'h01, 1'b0, 1'b0);
      check_flags("badcs", 1'b0, 1'b1);
      tick();
      check_log("badcs", 1);
      frame_words[0] = 32'h1234_5678;
      send_frame(8'd1, 1, 8'h00, 1'b0, 1'b0);
      check_flags("restart", 1'b1, 1'b0);
      tick();
      check_log("restart", 1);

      // Backpressure gaps and a start pulse in the middle of the frame
      for (int i = 0; i < 5; i++) frame_words[i] = 32'h0F1E_2D3C + 32'(i) * 32'h1111_1111;
      send_frame(8'd5, 5, 8'h00, 1'b1, 1'b1);
      check_flags("gaps", 1'b1, 1'b0);
      tick();
      check_log("gaps", 5);

      // Reset after two bytes of word 1
      log_addr.delete();
      log_data.delete();
      pulse_start();
      send_byte(8'd2, 0);
      send_byte(8'hC0, 0);
      send_byte(8'hFF, 0);
      send_byte(8'hEE, 0);
      send_byte(8'h01, 0);
      send_byte(8'h77, 0);
      send_byte(8'h66, 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_state("midreset");
      frame_words[0] = 32'h0BAD_F00D;
      send_frame(8'd1, 1, 8'h00, 1'b0, 1'b0);
      check_flags("after_reset", 1'b1, 1'b0);
      tick();
      check_log("after_reset", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
